// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Microprogrammed control sequencer. A 256 x 40-bit control store is loaded
//   through the programming port while idle; a run request then executes
//   microinstructions from address 0. Each microinstruction is held for
//   three clocks (phase 0, 1, 2). At the end of phase 2 either the word's HALT
//   bit returns the block to idle, or the next micro-address is formed from
//   next_addr, the JAMN/JAMZ flag conditions and the JMPC MBR merge.
//
//   Control word: [39:32] next_addr, [31] JMPC, [30] JAMN, [29] JAMZ,
//                 [28] HALT, [27:0] datapath mir.
//
// Ports
//   clock      in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset (store is not cleared)
//   run        in   1   start request, honoured in idle only
//   prog_we    in   1   control-store write enable, honoured in idle only
//   prog_addr  in   8   control-store write address
//   prog_data  in  40   control-store write word
//   n_flag     in   1   ALU negative flag, sampled at the phase-2 edge
//   z_flag     in   1   ALU zero flag, sampled at the phase-2 edge
//   mbr        in   8   MBR byte merged into the address by JMPC
//   mir        out 28   datapath microinstruction (0 when idle)
//   mpc        out  8   current micro-address
//   phase      out  2   microcycle phase 0..2
//   busy       out  1   high while executing
module micro_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [39:0] prog_data,
  input  logic        n_flag,
  input  logic        z_flag,
  input  logic [7:0]  mbr,
  output logic [27:0] mir,
  output logic [7:0]  mpc,
  output logic [1:0]  phase,
  output logic        busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [39:0] store [0:255];

  // Sequencing fields of the word currently in mir:
  // [11:4] next_addr, [3] JMPC, [2] JAMN, [1] JAMZ, [0] HALT.
  logic [11:0] ctl;

  logic [7:0]  next_mpc;
  logic [39:0] next_word;
  logic [39:0] start_word;

  // Address formation is pure OR-ing into an 8-bit value: a JAM onto an
  // address that already has bit 7 set, or a JMPC with overlapping bits,
  // never carries.
  function automatic logic [7:0] next_addr_f(input logic [11:0] c,
                                             input logic        n,
                                             input logic        z,
                                             input logic [7:0]  b);
    logic [7:0] a;
    a = c[11:4];
    if ((c[2] & n) | (c[1] & z)) a[7] = 1'b1;
    if (c[3]) a = a | b;
    return a;
  endfunction

  assign next_mpc   = next_addr_f(ctl, n_flag, z_flag, mbr);
  assign next_word  = store[next_mpc];
  assign start_word = store[8'd0];

  // Control store: no reset, so a program survives reset_n. Writes are
  // locked out while running so the executing program cannot change.
  always_ff @(posedge clock) begin
    if (state == IDLE && prog_we) store[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mir   <= '0;
      mpc   <= '0;
      phase <= '0;
      busy  <= 1'b0;
      ctl   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A simultaneous write takes priority; the start is dropped.
          if (run && !prog_we) begin
            state <= RUN;
            mpc   <= 8'd0;
            mir   <= start_word[27:0];
            ctl   <= start_word[39:28];
            phase <= 2'd0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (phase != 2'd2) begin
            phase <= phase + 2'd1;
          end else if (ctl[0]) begin
            // HALT: JAM/JMPC fields of this word are irrelevant.
            state <= IDLE;
            mir   <= '0;
            mpc   <= '0;
            phase <= '0;
            busy  <= 1'b0;
            ctl   <= '0;
          end else begin
            mpc   <= next_mpc;
            mir   <= next_word[27:0];
            ctl   <= next_word[39:28];
            phase <= 2'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        run = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = 8'd0;
  logic [39:0] prog_data = 40'd0;
  logic        n_flag = 1'b0;
  logic        z_flag = 1'b0;
  logic [7:0]  mbr = 8'd0;
  logic [27:0] mir;
  logic [7:0]  mpc;
  logic [1:0]  phase;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0]  mpc;
    logic [27:0] mir;
  } exp_t;

  exp_t        exp_q[$];
  logic [39:0] mdl [0:255];
  logic [7:0]  mdl_pc;
  exp_t        cur;
  bit          prev_busy = 1'b0;
  logic [1:0]  prev_phase = 2'd0;
  bit          halted;

  micro_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .n_flag    (n_flag),
    .z_flag    (z_flag),
    .mbr       (mbr),
    .mir       (mir),
    .mpc       (mpc),
    .phase     (phase),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [39:0] mk_word(input logic [7:0] na, input logic [2:0] jmp,
                                          input logic halt, input logic [27:0] m);
    return {na, jmp, halt, m};
  endfunction

  function automatic logic [39:0] rand_word();
    return {8'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0), 28'($urandom)};
  endfunction

  // Monitor: a new microinstruction appears whenever busy with phase 0;
  // it must match the next scoreboard entry and stay put through phases 1-2.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_busy  = 1'b0;
      prev_phase = 2'd0;
    end else begin
      if (busy) begin
        if (phase == 2'd0) begin
          check("instr_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("mpc", 64'(mpc), 64'(cur.mpc));
            check("mir", 64'(mir), 64'(cur.mir));
          end
          if (prev_busy) check("phase_wrap", 64'(prev_phase), 64'd2);
        end else begin
          check("phase_range", 64'(phase == 2'd3), 64'd0);
          check("phase_step", 64'({prev_busy, prev_phase}), 64'({1'b1, 2'(phase - 2'd1)}));
          check("hold_mpc", 64'(mpc), 64'(cur.mpc));
          check("hold_mir", 64'(mir), 64'(cur.mir));
        end
      end else begin
        check("idle_mir", 64'(mir), 64'd0);
        check("idle_phase", 64'(phase), 64'd0);
        check("idle_mpc", 64'(mpc), 64'd0);
      end
      prev_busy  = busy;
      prev_phase = phase;
    end
  end

  task automatic write_word(input logic [7:0] a, input logic [39:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clock); #1;
    prog_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic start_prog();
    run = 1'b1; prog_we = 1'b0;
    mdl_pc = 8'd0;
    exp_q.push_back({8'd0, mdl[0][27:0]});
    @(posedge clock); #1;
    run = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
  endtask

  // One microinstruction: junk flags/run/writes in phases 0-1, the given
  // flags at the phase-2 edge; the model follows the sequencing rules.
  task automatic exec_instr(input logic n, input logic z, input logic [7:0] m, output bit hlt);
    logic [39:0] w;
    logic [7:0]  a;
    hlt = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (p < 2) begin
        n_flag = 1'($urandom); z_flag = 1'($urandom); mbr = 8'($urandom);
      end else begin
        n_flag = n; z_flag = z; mbr = m;
      end
      run       = 1'($urandom);
      prog_we   = 1'($urandom);
      prog_addr = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
      prog_data = {8'($urandom), $urandom};
      if (p == 2) begin
        w = mdl[mdl_pc];
        if (w[28]) begin
          hlt = 1'b1;
        end else begin
          a = w[39:32];
          if ((w[30] && n) || (w[29] && z)) a = a | 8'h80;
          if (w[31]) a = a | m;
          mdl_pc = a;
          exp_q.push_back({a, mdl[a][27:0]});
        end
      end
      @(posedge clock); #1;
    end
    run = 1'b0; prog_we = 1'b0;
    if (hlt) begin
      check("halt_busy", 64'(busy), 64'd0);
      check("halt_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_mir", 64'(mir), 64'd0);
    check("rst_mpc", 64'(mpc), 64'd0);
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    reset_n = 1'b0;
    #1;
    check("init_mir", 64'(mir), 64'd0);
    check("init_mpc", 64'(mpc), 64'd0);
    check("init_phase", 64'(phase), 64'd0);
    check("init_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Program-and-run
    write_word(8'h00, mk_word(8'h01, 3'b000, 1'b0, 28'h6201A00));
    write_word(8'h01, mk_word(8'h00, 3'b000, 1'b1, 28'h0000000));
    start_prog();
    check("p0_mir", 64'(mir), 64'h6201A00);
    exec_instr(1'b1, 1'b1, 8'hFF, halted);
    check("p1_mpc", 64'(mpc), 64'h01);
    check("p1_mir", 64'(mir), 64'h0);
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    check("p_halted", 64'(halted), 64'd1);

    // Reset during phase 1 of mpc=1, then rerun to show store retention
    start_prog();
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    @(posedge clock); #1;
    check("pre_rst_phase", 64'(phase), 64'd1);
    do_reset();
    repeat (3) @(posedge clock);
    #1;
    check("no_autostart", 64'(busy), 64'd0);
    start_prog();
    check("retained_mir", 64'(mir), 64'h6201A00);
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    exec_instr(1'b0, 1'b0, 8'h00, halted);

    // JAMZ
    write_word(8'h00, mk_word(8'h02, 3'b000, 1'b0, 28'h1111111));
    write_word(8'h02, mk_word(8'h10, 3'b001, 1'b0, 28'h2222222));
    write_word(8'h90, mk_word(8'h00, 3'b000, 1'b1, 28'h3333333));
    write_word(8'h10, mk_word(8'h00, 3'b000, 1'b1, 28'h4444444));
    start_prog();
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    exec_instr(1'b1, 1'b1, 8'hFF, halted);
    check("jamz_set", 64'(mpc), 64'h90);
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    start_prog();
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    exec_instr(1'b1, 1'b0, 8'h00, halted);
    check("jamz_clr", 64'(mpc), 64'h10);
    exec_instr(1'b0, 1'b0, 8'h00, halted);

    // JMPC alone, then JMPC combined with JAMN
    write_word(8'h00, mk_word(8'h03, 3'b000, 1'b0, 28'h0ABCDEF));
    write_word(8'h03, mk_word(8'h00, 3'b100, 1'b0, 28'h5555555));
    write_word(8'h5A, mk_word(8'h00, 3'b000, 1'b1, 28'h6666666));
    start_prog();
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    exec_instr(1'b1, 1'b1, 8'h5A, halted);
    check("jmpc", 64'(mpc), 64'h5A);
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    write_word(8'h00, mk_word(8'h04, 3'b000, 1'b0, 28'h0FEDCBA));
    write_word(8'h04, mk_word(8'h80, 3'b110, 1'b0, 28'h7777777));
    write_word(8'h8F, mk_word(8'h00, 3'b000, 1'b1, 28'h8888888));
    start_prog();
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    exec_instr(1'b1, 1'b0, 8'h0F, halted);
    check("jmpc_jamn", 64'(mpc), 64'h8F);
    exec_instr(1'b0, 1'b0, 8'h00, halted);

    // 0xFF with both JAMs stays 0xFF
    write_word(8'h00, mk_word(8'h05, 3'b000, 1'b0, 28'h0000001));
    write_word(8'h05, mk_word(8'hFF, 3'b011, 1'b0, 28'h9999999));
    write_word(8'hFF, mk_word(8'h00, 3'b000, 1'b1, 28'hAAAAAAA));
    start_prog();
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    exec_instr(1'b1, 1'b1, 8'h00, halted);
    check("ff_no_carry", 64'(mpc), 64'hFF);
    exec_instr(1'b0, 1'b0, 8'h00, halted);

    // Self-loop re-executes until reset
    write_word(8'h00, mk_word(8'h06, 3'b000, 1'b0, 28'h0000002));
    write_word(8'h06, mk_word(8'h06, 3'b000, 1'b0, 28'hBBBBBBB));
    start_prog();
    for (int i = 0; i < 5; i++) begin
      exec_instr(1'($urandom), 1'($urandom), 8'($urandom), halted);
      check("self_loop", 64'(mpc), 64'h06);
    end
    do_reset();

    // Randomized programs
    for (int i = 0; i < 256; i++) write_word(8'(i), rand_word());
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < 4; k++) write_word(8'($urandom), rand_word());
      start_prog();
      halted = 1'b0;
      for (int s = 0; s < 20 && !halted; s++)
        exec_instr(1'($urandom), 1'($urandom), 8'($urandom), halted);
      if (!halted) do_reset();
      @(posedge clock); #1;
    end

    // run together with prog_we: write only, stay idle
    run = 1'b1; prog_we = 1'b1; prog_addr = 8'h00;
    prog_data = mk_word(8'h00, 3'b000, 1'b1, 28'h1234567);
    @(posedge clock); #1;
    run = 1'b0; prog_we = 1'b0;
    mdl[0] = mk_word(8'h00, 3'b000, 1'b1, 28'h1234567);
    check("run_we_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    start_prog();
    check("run_we_written", 64'(mir), 64'h1234567);
    exec_instr(1'b0, 1'b0, 8'h00, halted);
    check("run_we_halt", 64'(halted), 64'd1);

    repeat (2) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
